eth_tx_frame_arb: RTL

ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

---
 rtl/eth_tx_frame_arb.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_arb.sv
// Two-requester Ethernet TX frame arbiter. It owns the header handshake and the
// payload byte stream towards a single eth_axis_tx. Arbitration is round-robin,
// and one frame is carried at a time. Each requester has a counter of completed
// frames.
module eth_tx_frame_arb #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  output logic                 req0_ack,
  input  logic [47:0]          req0_dest_mac,
  input  logic [47:0]          req0_src_mac,
  input  logic [15:0]          req0_type,
  input  logic [7:0]           req0_tdata,
  input  logic                 req0_tvalid,
  input  logic                 req0_tlast,
  output logic                 req0_tready,

  input  logic                 req1_valid,
  output logic                 req1_ack,
  input  logic [47:0]          req1_dest_mac,
  input  logic [47:0]          req1_src_mac,
  input  logic [15:0]          req1_type,
  input  logic [7:0]           req1_tdata,
  input  logic                 req1_tvalid,
  input  logic                 req1_tlast,
  output logic                 req1_tready,

  output logic                 s_eth_hdr_valid,
  input  logic                 s_eth_hdr_ready,
  output logic [47:0]          s_eth_dest_mac,
  output logic [47:0]          s_eth_src_mac,
  output logic [15:0]          s_eth_type,

  output logic [7:0]           s_eth_payload_axis_tdata,
  output logic                 s_eth_payload_axis_tvalid,
  output logic                 s_eth_payload_axis_tlast,
  output logic                 s_eth_payload_axis_tuser,
  input  logic                 s_eth_payload_axis_tready,

  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] frame_count0,
  output logic [CNT_WIDTH-1:0] frame_count1
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t               state_q;
  logic [1:0]           grant_q;
  logic [1:0]           ack_q;
  logic                 last_q;      // index of the requester granted most recently
  logic                 hdr_valid_q;
  logic [47:0]          dest_q;
  logic [47:0]          src_q;
  logic [15:0]          type_q;
  logic [CNT_WIDTH-1:0] cnt0_q;
  logic [CNT_WIDTH-1:0] cnt1_q;

  logic                 winner_d;
  logic [CNT_WIDTH-1:0] cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_d;
  logic                 pl_active_s;
  logic                 beat_last_s;

  assign req0_ack        = ack_q[0];
  assign req1_ack        = ack_q[1];
  assign grant           = grant_q;
  assign s_eth_hdr_valid = hdr_valid_q;
  assign s_eth_dest_mac  = dest_q;
  assign s_eth_src_mac   = src_q;
  assign s_eth_type      = type_q;
  assign frame_count0    = cnt0_q;
  assign frame_count1    = cnt1_q;
  assign s_eth_payload_axis_tuser = 1'b0;

  // Round-robin pick: on a tie, the requester not served last wins.
  always_comb begin
    winner_d = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_d = ~last_q;
    end else if (req1_valid) begin
      winner_d = 1'b1;
    end else begin
      winner_d = 1'b0;
    end
  end

  // Wrapping increments for the completed-frame counters.
  always_comb begin
    cnt0_d = cnt0_q + CNT_WIDTH'(1);
    cnt1_d = cnt1_q + CNT_WIDTH'(1);
  end

  // Payload path muxed from the granted requester. It is gated off during reset,
  // so no handshake can complete in the reset cycle.
  always_comb begin
    pl_active_s               = (state_q == PAYLOAD) && !rst;
    s_eth_payload_axis_tdata  = 8'h00;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    req0_tready               = 1'b0;
    req1_tready               = 1'b0;
    if (pl_active_s) begin
      if (grant_q[1]) begin
        s_eth_payload_axis_tdata  = req1_tdata;
        s_eth_payload_axis_tvalid = req1_tvalid;
        s_eth_payload_axis_tlast  = req1_tlast;
        req1_tready               = s_eth_payload_axis_tready;
      end else begin
        s_eth_payload_axis_tdata  = req0_tdata;
        s_eth_payload_axis_tvalid = req0_tvalid;
        s_eth_payload_axis_tlast  = req0_tlast;
        req0_tready               = s_eth_payload_axis_tready;
      end
    end else begin
      s_eth_payload_axis_tdata  = 8'h00;
    end
    beat_last_s = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready &&
                  s_eth_payload_axis_tlast;
  end

  // Frame FSM: arbitrate and latch the header, present the header, then stream
  // the payload until its last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      ack_q       <= 2'b00;
      last_q      <= 1'b1;
      hdr_valid_q <= 1'b0;
      dest_q      <= 48'h0;
      src_q       <= 48'h0;
      type_q      <= 16'h0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 2'b00;
          if (req0_valid || req1_valid) begin
            state_q     <= HDR;
            hdr_valid_q <= 1'b1;
            last_q      <= winner_d;
            if (winner_d) begin
              grant_q <= 2'b10;
              ack_q   <= 2'b10;
              dest_q  <= req1_dest_mac;
              src_q   <= req1_src_mac;
              type_q  <= req1_type;
            end else begin
              grant_q <= 2'b01;
              ack_q   <= 2'b01;
              dest_q  <= req0_dest_mac;
              src_q   <= req0_src_mac;
              type_q  <= req0_type;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        HDR: begin
          ack_q <= 2'b00;
          if (hdr_valid_q && s_eth_hdr_ready) begin
            hdr_valid_q <= 1'b0;
            state_q     <= PAYLOAD;
          end else begin
            state_q <= HDR;
          end
        end
        PAYLOAD: begin
          ack_q <= 2'b00;
          if (beat_last_s) begin
            grant_q <= 2'b00;
            state_q <= IDLE;
            if (grant_q[1]) begin
              cnt1_q <= cnt1_d;
            end else begin
              cnt0_q <= cnt0_d;
            end
          end else begin
            state_q <= PAYLOAD;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant_q     <= 2'b00;
          ack_q       <= 2'b00;
          hdr_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
